axist_tx_pkt_rr_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that shares the single TX AXI-ST input of the AXI-ST to AVST bridge between NUM_STREAMS independent single-packet AXI-ST sources.
- Holds a grant from first beat to the tlast handshake, so packets are never interleaved toward the MAC.
- Sits between the per-stream user/DMA TX logic and the bridge's i_axi_st_tx_* port.

---
 rtl/axist_tx_arb_pkg.sv | 17 +
 rtl/axist_rr_pick.sv | 20 ++
 rtl/axist_tx_pkt_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_axist_tx_pkt_rr_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axist_tx_arb_pkg.sv
// axist_tx_arb_pkg: shared types and helpers for the packet round-robin TX arbiter.
package axist_tx_arb_pkg;

    typedef enum logic {IDLE = 1'b0, PKT = 1'b1} arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int DEFAULT_NUM_STREAMS = 4;
    localparam int STREAM_IDX_W = idx_width(DEFAULT_NUM_STREAMS);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/axist_rr_pick.sv
// axist_rr_pick: first set request at or after ptr, ascending with wrap-around; one-hot result.
module axist_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     win,
    output logic             valid
);
    logic [N-1:0] mask, hi, sel;

    // Requests at or above ptr take priority; otherwise wrap to the lowest requester.
    assign mask  = ~((N'(1) << ptr) - N'(1));
    assign hi    = req & mask;
    assign sel   = (|hi) ? hi : req;
    assign win   = sel & (~sel + N'(1));
    assign valid = |req;

endmodule

// File: rtl/axist_tx_pkt_rr_arbiter.sv
// axist_tx_pkt_rr_arbiter: packet-granular round-robin merge of NUM_STREAMS AXI-ST sources.
// Define AXIST_ARB_PKT_CNT_EN to add saturating per-stream completed-packet counters.
module axist_tx_pkt_rr_arbiter
    import axist_tx_arb_pkg::*;
#(
    parameter int NUM_STREAMS = 4,
    parameter int TDATA_WIDTH = 64,
    parameter int NO_OF_BYTES = TDATA_WIDTH / 8,
    parameter int TUSER_WIDTH = 16
) (
    input  logic                               i_tx_clk,
    input  logic                               i_tx_reset,
    input  logic [NUM_STREAMS-1:0]             i_stream_en,
    input  logic [NUM_STREAMS-1:0]             i_axist_tvalid,
    input  logic [NUM_STREAMS*TDATA_WIDTH-1:0] i_axist_tdata,
    input  logic [NUM_STREAMS-1:0]             i_axist_tlast,
    input  logic [NUM_STREAMS*NO_OF_BYTES-1:0] i_axist_tkeep,
    input  logic [NUM_STREAMS*TUSER_WIDTH-1:0] i_axist_tuser,
    output logic [NUM_STREAMS-1:0]             o_axist_tready,
    output logic                               o_axist_tvalid,
    output logic [TDATA_WIDTH-1:0]             o_axist_tdata,
    output logic                               o_axist_tlast,
    output logic [NO_OF_BYTES-1:0]             o_axist_tkeep,
    output logic [TUSER_WIDTH-1:0]             o_axist_tuser,
    input  logic                               i_axist_tready,
    output logic [NUM_STREAMS-1:0]             o_grant,
    output logic                               o_busy
`ifdef AXIST_ARB_PKT_CNT_EN
    ,
    input  logic                               i_pkt_cnt_clr,
    output logic [NUM_STREAMS*32-1:0]          o_pkt_cnt
`endif
);
    localparam int IDX_W = idx_width(NUM_STREAMS);

    arb_state_t              state, state_n;
    logic [NUM_STREAMS-1:0]  grant_q, grant_n, req, pick_win;
    logic [IDX_W-1:0]        ptr, ptr_n, pick_ptr, g_idx, g_next;
    logic                    pick_valid, act, done;
    logic                    sel_tvalid, sel_tlast;
    logic [TDATA_WIDTH-1:0]  sel_tdata;
    logic [NO_OF_BYTES-1:0]  sel_tkeep;
    logic [TUSER_WIDTH-1:0]  sel_tuser;

    assign req = i_axist_tvalid & i_stream_en;

    always_comb begin
        g_idx      = '0;
        sel_tvalid = 1'b0;
        sel_tlast  = 1'b0;
        sel_tdata  = '0;
        sel_tkeep  = '0;
        sel_tuser  = '0;
        for (int k = 0; k < NUM_STREAMS; k++) begin
            if (grant_q[k]) begin
                g_idx      = IDX_W'(k);
                sel_tvalid = i_axist_tvalid[k];
                sel_tlast  = i_axist_tlast[k];
                sel_tdata  = i_axist_tdata[k*TDATA_WIDTH +: TDATA_WIDTH];
                sel_tkeep  = i_axist_tkeep[k*NO_OF_BYTES +: NO_OF_BYTES];
                sel_tuser  = i_axist_tuser[k*TUSER_WIDTH +: TUSER_WIDTH];
            end
        end
    end

    // Outputs are forced quiet while reset is applied, even before the state register clears.
    assign act            = (state == PKT) && !i_tx_reset;
    assign o_axist_tvalid = act && sel_tvalid;
    assign o_axist_tlast  = act && sel_tlast;
    assign o_axist_tdata  = act ? sel_tdata : '0;
    assign o_axist_tkeep  = act ? sel_tkeep : '0;
    assign o_axist_tuser  = act ? sel_tuser : '0;
    assign o_axist_tready = {NUM_STREAMS{act && i_axist_tready}} & grant_q;
    assign o_grant        = grant_q;
    assign o_busy         = (state == PKT);

    assign done     = o_axist_tvalid && i_axist_tready && sel_tlast;
    assign g_next   = (g_idx == IDX_W'(NUM_STREAMS - 1)) ? '0 : g_idx + IDX_W'(1);
    assign pick_ptr = done ? g_next : ptr;

    axist_rr_pick #(.N(NUM_STREAMS), .IDX_W(IDX_W)) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .win   (pick_win),
        .valid (pick_valid)
    );

    always_ff @(posedge i_tx_clk) begin
        if (i_tx_reset) begin
            state   <= IDLE;
            grant_q <= '0;
            ptr     <= '0;
        end else begin
            state   <= state_n;
            grant_q <= grant_n;
            ptr     <= ptr_n;
        end
    end

    // tlast re-arbitrates in the same cycle so back-to-back packets see no bubble.
    always_comb begin
        state_n = state;
        grant_n = grant_q;
        ptr_n   = ptr;
        if (state == IDLE) begin
            state_n = pick_valid ? PKT : IDLE;
            grant_n = pick_valid ? pick_win : '0;
        end else if (done) begin
            ptr_n   = g_next;
            state_n = pick_valid ? PKT : IDLE;
            grant_n = pick_valid ? pick_win : '0;
        end
    end

`ifdef AXIST_ARB_PKT_CNT_EN
    logic [NUM_STREAMS-1:0][31:0] cnt;

    always_ff @(posedge i_tx_clk) begin
        if (i_tx_reset || i_pkt_cnt_clr) begin
            cnt <= '0;
        end else if (done) begin
            for (int k = 0; k < NUM_STREAMS; k++) begin
                if (grant_q[k]) cnt[k] <= sat_inc(cnt[k]);
            end
        end
    end

    assign o_pkt_cnt = cnt;
`endif

endmodule

// File: tb/tb_axist_tx_pkt_rr_arbiter.sv
// tb_axist_tx_pkt_rr_arbiter: directed stimulus with a cycle-level reference model of the arbiter.
module tb_axist_tx_pkt_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int UW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] en = '1;
    logic i_tready = 1'b1;
    logic [N-1:0] tvalid = '0;
    logic [N-1:0] tlast = '0;
    logic [N*DW-1:0] tdata = '0;
    logic [N*KW-1:0] tkeep = '0;
    logic [N*UW-1:0] tuser = '0;
    logic [N-1:0] o_tready, o_grant;
    logic o_tvalid, o_tlast, o_busy;
    logic [DW-1:0] o_tdata;
    logic [KW-1:0] o_tkeep;
    logic [UW-1:0] o_tuser;
`ifdef AXIST_ARB_PKT_CNT_EN
    logic pkt_clr = 1'b0;
    logic [N*32-1:0] pkt_cnt;
`endif

    beat_t mem [N][64];
    int hd [N] = '{default: 0};
    int tl [N] = '{default: 0};
    logic [N-1:0] hold = '0;
    bit flush = 1'b0;

    int checks = 0;
    int passes = 0;
    int out_beats = 0;
    int cyc = 0;
    logic [DW-1:0] obd [256];
    int obs [256];
    bit obl [256];
    int obc [256];

    bit m_busy = 1'b0;
    int m_g = 0;
    int m_ptr = 0;

    always #5 clk = ~clk;

    axist_tx_pkt_rr_arbiter #(.NUM_STREAMS(N), .TDATA_WIDTH(DW), .NO_OF_BYTES(KW), .TUSER_WIDTH(UW)) dut (
        .i_tx_clk       (clk),
        .i_tx_reset     (rst),
        .i_stream_en    (en),
        .i_axist_tvalid (tvalid),
        .i_axist_tdata  (tdata),
        .i_axist_tlast  (tlast),
        .i_axist_tkeep  (tkeep),
        .i_axist_tuser  (tuser),
        .o_axist_tready (o_tready),
        .o_axist_tvalid (o_tvalid),
        .o_axist_tdata  (o_tdata),
        .o_axist_tlast  (o_tlast),
        .o_axist_tkeep  (o_tkeep),
        .o_axist_tuser  (o_tuser),
        .i_axist_tready (i_tready),
        .o_grant        (o_grant),
        .o_busy         (o_busy)
`ifdef AXIST_ARB_PKT_CNT_EN
        ,
        .i_pkt_cnt_clr  (pkt_clr),
        .o_pkt_cnt      (pkt_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [DW-1:0] exp_d(input int k, input int tag, input int i);
        return DW'(k * 4096 + tag * 16 + i);
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int o = 0; o < N; o++) if (r[(p + o) % N]) return (p + o) % N;
        return -1;
    endfunction

    function automatic int oh2i(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    function automatic int nth_pkt(input int base, input int n);
        int c = 0;
        for (int i = base; i < out_beats && i < 256; i++) begin
            if (obl[i]) begin
                if (c == n) return obs[i];
                c++;
            end
        end
        return -1;
    endfunction

    task automatic push(input int k, input int n, input int tag);
        for (int i = 0; i < n; i++) begin
            mem[k][tl[k] % 64] = '{data: exp_d(k, tag, i), last: (i == n - 1),
                                   keep: (i == n - 1) ? 8'h0F : 8'hFF, user: UW'(k * 256 + i)};
            tl[k]++;
        end
    endtask

    task automatic step_in;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input string name, input int n, input int budget);
        for (int i = 0; i < budget && out_beats < n; i++) @(posedge clk);
        chk(name, 64'(out_beats >= n), 64'd1);
    endtask

    task automatic do_reset;
        @(negedge clk);
        flush = 1'b1;
        hold = '0;
        step_in;
        rst = 1'b1;
        en = '1;
        i_tready = 1'b1;
        step_in;
        rst = 1'b0;
        @(negedge clk);
        flush = 1'b0;
    endtask

    // Sources: hold each beat until the arbiter acks it.
    initial begin
        logic [N-1:0] ack;
        beat_t b;
        forever begin
            @(negedge clk);
            ack = tvalid & o_tready;
            step_in;
            for (int k = 0; k < N; k++) begin
                if (flush) hd[k] = tl[k];
                else if (ack[k]) hd[k]++;
                b = (hd[k] != tl[k]) ? mem[k][hd[k] % 64] : '0;
                tvalid[k] = (hd[k] != tl[k]) && !hold[k];
                tlast[k] = b.last;
                tdata[k*DW +: DW] = b.data;
                tkeep[k*KW +: KW] = b.keep;
                tuser[k*UW +: UW] = b.user;
            end
        end
    end

    // Reference model: current grant index, busy flag and pointer as plain integers.
    initial begin
        logic [N-1:0] req;
        bit act, exp_tv;
        int w;
        forever begin
            @(negedge clk);
            cyc++;
            req = tvalid & en;
            act = !rst && m_busy;
            exp_tv = act && tvalid[m_g];
            chk("tvalid", 64'(o_tvalid), 64'(exp_tv));
            chk("grant", 64'(o_grant), m_busy ? 64'(1 << m_g) : 64'd0);
            chk("busy", 64'(o_busy), 64'(m_busy));
            chk("tready", 64'(o_tready), (act && i_tready) ? 64'(1 << m_g) : 64'd0);
            if (exp_tv) begin
                chk("tdata", o_tdata, tdata[m_g*DW +: DW]);
                chk("tlast", 64'(o_tlast), 64'(tlast[m_g]));
                chk("tkeep", 64'(o_tkeep), 64'(tkeep[m_g*KW +: KW]));
                chk("tuser", 64'(o_tuser), 64'(tuser[m_g*UW +: UW]));
            end
            if (o_tvalid === 1'b1 && i_tready && out_beats < 256) begin
                obd[out_beats] = o_tdata;
                obs[out_beats] = oh2i(o_grant);
                obl[out_beats] = o_tlast;
                obc[out_beats] = cyc;
                out_beats++;
            end
            if (rst) begin
                m_busy = 1'b0;
                m_g = 0;
                m_ptr = 0;
            end else if (!m_busy) begin
                w = pick(req, m_ptr);
                if (w >= 0) begin
                    m_busy = 1'b1;
                    m_g = w;
                end
            end else if (tvalid[m_g] && i_tready && tlast[m_g]) begin
                m_ptr = (m_g + 1) % N;
                w = pick(req, m_ptr);
                if (w >= 0) m_g = w;
                else m_busy = 1'b0;
            end
        end
    end

    initial begin
        int base, rb, hits;
        int exp2 [5] = '{0, 1, 2, 3, 0};
        int exp5 [3] = '{0, 1, 3};
        do_reset;
        chk("reset_grant", 64'(o_grant), 64'd0);
        chk("reset_busy", 64'(o_busy), 64'd0);
        chk("reset_tvalid", 64'(o_tvalid), 64'd0);

        // Single stream 1, 3 beats: one bubble, then a sole requester keeps winning.
        base = out_beats;
        push(1, 3, 1);
        @(negedge clk);
        chk("t1_bubble_tvalid", 64'(o_tvalid), 64'd0);
        chk("t1_bubble_busy", 64'(o_busy), 64'd0);
        @(negedge clk);
        chk("t1_grant", 64'(o_grant), 64'b0010);
        chk("t1_first_tvalid", 64'(o_tvalid), 64'd1);
        wait_beats("t1_wait", base + 3, 20);
        for (int i = 0; i < 3; i++) chk($sformatf("t1_data%0d", i), obd[base + i], exp_d(1, 1, i));
        @(negedge clk);
        chk("t1_regrant_same", 64'(o_grant), 64'b0010);
        push(1, 1, 2);
        push(3, 1, 2);
        wait_beats("t1_wait2", base + 5, 20);
        chk("t1_ptr_pkt_a", 64'(nth_pkt(base, 1)), 64'd1);
        chk("t1_ptr_pkt_b", 64'(nth_pkt(base, 2)), 64'd3);

        // All streams requesting: 0,1,2,3,0 with no bubbles.
        do_reset;
        base = out_beats;
        for (int k = 0; k < N; k++) begin
            push(k, 2, 1);
            push(k, 2, 2);
        end
        wait_beats("t2_wait", base + 16, 60);
        for (int i = 0; i < 5; i++) chk($sformatf("t2_pkt%0d", i), 64'(nth_pkt(base, i)), 64'(exp2[i]));
        chk("t2_no_bubble", 64'(obc[base + 15] - obc[base]), 64'd15);

        // Granted stream 0 stalls mid-packet while stream 2 waits.
        do_reset;
        base = out_beats;
        push(0, 4, 3);
        push(2, 1, 3);
        wait_beats("t3_wait_first", base + 1, 20);
        hold[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_grant", 64'(o_grant), 64'b0001);
            chk("t3_hold_tready2", 64'(o_tready[2]), 64'd0);
        end
        hold[0] = 1'b0;
        wait_beats("t3_wait_all", base + 5, 30);
        for (int i = 0; i < 4; i++) chk($sformatf("t3_data%0d", i), obd[base + i], exp_d(0, 3, i));
        chk("t3_next_s2", 64'(nth_pkt(base, 1)), 64'd2);

        // Toggling downstream tready: each beat crosses once, in order.
        do_reset;
        base = out_beats;
        push(3, 4, 4);
        for (int i = 0; i < 16; i++) begin
            step_in;
            i_tready = ~i_tready;
        end
        i_tready = 1'b1;
        @(negedge clk);
        chk("t4_beats", 64'(out_beats - base), 64'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("t4_data%0d", i), obd[base + i], exp_d(3, 4, i));

        // Masked stream 2 never wins; clearing en[1] mid-packet lets it finish.
        do_reset;
        step_in;
        en = 4'b1011;
        @(negedge clk);
        base = out_beats;
        for (int k = 0; k < N; k++) push(k, 3, 5);
        for (int i = 0; i < 40 && o_grant !== 4'b0010; i++) @(negedge clk);
        chk("t5_grant_s1", 64'(o_grant), 64'b0010);
        step_in;
        en = 4'b1001;
        wait_beats("t5_wait", base + 9, 40);
        for (int i = 0; i < 3; i++) chk($sformatf("t5_pkt%0d", i), 64'(nth_pkt(base, i)), 64'(exp5[i]));
        hits = 0;
        for (int i = base; i < out_beats && i < 256; i++) if (obs[i] == 2) hits++;
        chk("t5_no_s2", 64'(hits), 64'd0);

        // Reset mid-packet, then lowest requester wins.
        do_reset;
        base = out_beats;
        push(2, 4, 6);
        wait_beats("t6_wait", base + 2, 20);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_tvalid", 64'(o_tvalid), 64'd0);
        chk("t6_rst_tready", 64'(o_tready), 64'd0);
        @(negedge clk);
        chk("t6_grant", 64'(o_grant), 64'd0);
        chk("t6_busy", 64'(o_busy), 64'd0);
        chk("t6_tvalid", 64'(o_tvalid), 64'd0);
        flush = 1'b1;
        step_in;
        rst = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        rb = out_beats;
        push(3, 1, 7);
        push(1, 1, 7);
        wait_beats("t6_wait2", rb + 1, 20);
        chk("t6_first_after", 64'(obs[rb]), 64'd1);

`ifdef AXIST_ARB_PKT_CNT_EN
        do_reset;
        base = out_beats;
        push(0, 1, 8);
        push(0, 1, 9);
        push(0, 1, 10);
        wait_beats("cnt_wait", base + 3, 20);
        @(negedge clk);
        chk("cnt_s0", 64'(pkt_cnt[31:0]), 64'd3);
        chk("cnt_s1", 64'(pkt_cnt[63:32]), 64'd0);
        step_in;
        pkt_clr = 1'b1;
        step_in;
        pkt_clr = 1'b0;
        @(negedge clk);
        chk("cnt_clr", 64'(pkt_cnt[31:0]), 64'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
